iir_out_requant: RTL and testbench

Downstream stage of the IIR filter: takes the filter's full-width signed output every clock and rescales it by a programmable arithmetic right shift. It saturates the result to the output width, decimates by a programmable factor, and buffers samples in a small first-word-fall-through FIFO. Samples leave through a valid/ready stream to the DAC/serializer side. Saturation and FIFO-overflow events are reported through sticky flags.

---
 rtl/iir_out_requant.sv | 159 +++++++++++++++
 tb/tb_iir_out_requant.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_out_requant.sv
// Output requantizer for the IIR filter: arithmetic shift, saturate, decimate, then buffer
// kept samples in a first-word-fall-through FIFO feeding a valid/ready stream.
module iir_out_requant #(
    parameter int unsigned DATA_IN_WIDTH  = 32,
    parameter int unsigned DATA_OUT_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned DECIM_WIDTH    = 8
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [DATA_IN_WIDTH-1:0]          data_in_i,
    input  logic                              in_valid_i,
    input  logic [4:0]                        shift_i,
    input  logic [DECIM_WIDTH-1:0]            decim_factor_i,
    input  logic                              clear_flags_i,
    output logic [DATA_OUT_WIDTH-1:0]         out_data_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]       fill_level_o,
    output logic                              sat_flag_o,
    output logic                              overflow_o
);

    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;

    localparam logic signed [DATA_IN_WIDTH-1:0] OutMax =
        DATA_IN_WIDTH'((2 ** (DATA_OUT_WIDTH - 1)) - 1);
    localparam logic signed [DATA_IN_WIDTH-1:0] OutMin = ~OutMax;

    // ------------------------------------------------------------------
    // Requant stage
    // ------------------------------------------------------------------
    logic signed [DATA_IN_WIDTH-1:0] shifted;
    logic                            sat_hi;
    logic                            sat_lo;
    logic [DATA_OUT_WIDTH-1:0]       requant;

    assign shifted = $signed(data_in_i) >>> shift_i;

    always_comb begin
        sat_hi  = shifted > OutMax;
        sat_lo  = shifted < OutMin;
        requant = shifted[DATA_OUT_WIDTH-1:0];
        if (sat_hi) begin
            requant = OutMax[DATA_OUT_WIDTH-1:0];
        end else if (sat_lo) begin
            requant = OutMin[DATA_OUT_WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Decimation counter
    // ------------------------------------------------------------------
    logic [DECIM_WIDTH-1:0] cnt_q;
    logic [DECIM_WIDTH-1:0] cnt_d;
    logic [DECIM_WIDTH-1:0] decim_last;
    logic                   keep;

    // >= rather than == so a lowered factor wraps immediately instead of sticking.
    always_comb begin
        decim_last = (decim_factor_i == '0) ? '0 : decim_factor_i - DECIM_WIDTH'(1);
        keep       = in_valid_i && (cnt_q == '0);
        cnt_d      = cnt_q;
        if (in_valid_i) begin
            cnt_d = (cnt_q >= decim_last) ? '0 : cnt_q + DECIM_WIDTH'(1);
        end
    end

    logic                      stg_valid_q;
    logic                      stg_keep_q;
    logic                      stg_sat_q;
    logic [DATA_OUT_WIDTH-1:0] stg_data_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q       <= '0;
            stg_valid_q <= 1'b0;
            stg_keep_q  <= 1'b0;
            stg_sat_q   <= 1'b0;
            stg_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            stg_valid_q <= in_valid_i;
            stg_keep_q  <= keep;
            stg_sat_q   <= sat_hi | sat_lo;
            stg_data_q  <= requant;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]           wr_ptr_q;
    logic [PtrW-1:0]           rd_ptr_q;
    logic [PtrW-1:0]           wr_ptr_d;
    logic [PtrW-1:0]           rd_ptr_d;
    logic                      empty;
    logic                      full;
    logic                      push;
    logic                      pop;
    logic                      wr_en;
    logic                      drop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
        push     = stg_valid_q && stg_keep_q;
        pop      = !empty && out_ready_i;
        // A pop in the same cycle frees the slot a full FIFO needs for the push.
        wr_en    = push && (!full || pop);
        drop     = push && full && !pop;
        wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= stg_data_q;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and sticky flags
    // ------------------------------------------------------------------
    logic sat_q;
    logic sat_d;
    logic ovf_q;
    logic ovf_d;

    always_comb begin
        sat_d = (push && stg_sat_q) || (sat_q && !clear_flags_i);
        ovf_d = drop || (ovf_q && !clear_flags_i);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sat_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sat_q    <= sat_d;
            ovf_q    <= ovf_d;
        end
    end

    // Head is forced to zero when empty so reset and drain present a clean bus.
    assign out_data_o   = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];
    assign out_valid_o  = !empty;
    assign fill_level_o = wr_ptr_q - rd_ptr_q;
    assign sat_flag_o   = sat_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_iir_out_requant.sv
// Self-checking bench for iir_out_requant: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_iir_out_requant;

    logic        clk;
    logic        reset;
    logic [31:0] data_in;
    logic        in_valid;
    logic [4:0]  shift;
    logic [7:0]  decim;
    logic        clear_flags;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fill;
    logic        sat_flag;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    iir_out_requant #(
        .DATA_IN_WIDTH (32),
        .DATA_OUT_WIDTH(16),
        .FIFO_DEPTH    (8),
        .DECIM_WIDTH   (8)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .data_in_i     (data_in),
        .in_valid_i    (in_valid),
        .shift_i       (shift),
        .decim_factor_i(decim),
        .clear_flags_i (clear_flags),
        .out_data_o    (out_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .fill_level_o  (fill),
        .sat_flag_o    (sat_flag),
        .overflow_o    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Behavioural model: one pending stage sample plus the FIFO contents as a queue.
    int m_q[$];
    bit m_sv, m_keep, m_ssat, m_sat, m_ov;
    int m_sval, m_cnt;

    task automatic m_reset();
        m_q.delete();
        m_sv = 0; m_keep = 0; m_ssat = 0; m_sat = 0; m_ov = 0;
        m_sval = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit pop, push, drop;
        int t, n;
        pop  = (m_q.size() > 0) && out_ready;
        push = m_sv && m_keep;
        drop = push && (m_q.size() == 8) && !pop;
        m_sat = (push && m_ssat) || (m_sat && !clear_flags);
        m_ov  = drop || (m_ov && !clear_flags);
        if (pop) void'(m_q.pop_front());
        if (push && !drop) m_q.push_back(m_sval);
        m_sv   = in_valid;
        m_keep = in_valid && (m_cnt == 0);
        if (in_valid) begin
            t      = $signed(data_in) >>> shift;
            m_ssat = (t > 32767) || (t < -32768);
            m_sval = (t > 32767) ? 32767 : ((t < -32768) ? -32768 : t);
            n      = (decim == 0) ? 1 : int'(decim);
            m_cnt  = (m_cnt >= n - 1) ? 0 : m_cnt + 1;
        end
    endtask

    function automatic int m_head();
        return (m_q.size() > 0) ? m_q[0] : 0;
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; clear_flags = 1'b0; out_ready = 1'b0;
        data_in = '0; shift = '0; decim = 8'd1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d want 0", out_valid); end
        checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_data got %0d want 0", out_data); end
        checks++; if (fill !== 4'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", fill); end
        checks++; if ({sat_flag, overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {sat_flag, overflow}); end
        reset = 1'b0;
        m_reset();
    endtask

    task automatic test_basic();
        do_reset();
        shift = 5'd13; decim = 8'd1; out_ready = 1'b1; data_in = 32'h0000_2000; in_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c >= 2) begin
                checks++; if (out_valid !== 1'b1 || $signed(out_data) !== 16'sd1) begin
                    errors++; $display("FAIL basic_out c=%0d got v=%0d d=%0d want v=1 d=1", c, out_valid, $signed(out_data)); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency got v=%0d want 0", out_valid); end
            end
            checks++; if (fill > 4'd1 || sat_flag !== 1'b0 || overflow !== 1'b0) begin
                errors++; $display("FAIL basic_fill_flags got fill=%0d sat=%0d ov=%0d want <=1,0,0", fill, sat_flag, overflow); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        shift = 5'd0; decim = 8'd1; out_ready = 1'b1; in_valid = 1'b1;
        data_in = 32'h0001_0000; step();
        data_in = 32'hFFFE_0000; step();
        checks++; if ($signed(out_data) !== 16'sd32767 || sat_flag !== 1'b1) begin
            errors++; $display("FAIL sat_pos got d=%0d sat=%0d want 32767,1", $signed(out_data), sat_flag); end
        in_valid = 1'b0; step();
        checks++; if (out_valid !== 1'b1 || $signed(out_data) !== -16'sd32768) begin
            errors++; $display("FAIL sat_neg got v=%0d d=%0d want 1,-32768", out_valid, $signed(out_data)); end
        step();
        checks++; if (sat_flag !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL sat_sticky got sat=%0d v=%0d want 1,0", sat_flag, out_valid); end
        clear_flags = 1'b1; step(); clear_flags = 1'b0;
        checks++; if (sat_flag !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL sat_clear got sat=%0d ov=%0d want 0,0", sat_flag, overflow); end
    endtask

    task automatic test_decimation();
        int got[$];
        int exp4[4] = '{0, 4, 8, 12};
        do_reset();
        shift = 5'd0; decim = 8'd4; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_in = i; step();
            if (out_valid) got.push_back(int'($signed(out_data)));
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (got.size() <= k || got[k] !== exp4[k]) begin
                errors++; $display("FAIL decim4_seq k=%0d got %0d want %0d", k, (got.size() > k) ? got[k] : -1, exp4[k]); end
        end
        got.delete();
        decim = 8'd0;
        for (int i = 16; i < 28; i++) begin
            data_in = i; step();
            checks++; if (out_valid !== (m_q.size() > 0) || int'($signed(out_data)) !== m_head()) begin
                errors++; $display("FAIL decim0_model got v=%0d d=%0d want d=%0d", out_valid, $signed(out_data), m_head()); end
            if (out_valid) got.push_back(int'($signed(out_data)));
        end
        for (int k = got.size() - 6; k < got.size() - 1; k++) begin
            checks++; if (k < 0 || got[k+1] !== got[k] + 1) begin
                errors++; $display("FAIL decim0_every got step at k=%0d want +1", k); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        shift = 5'd0; decim = 8'd1; out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin data_in = i; in_valid = 1'b1; step(); end
        in_valid = 1'b0; step(); step();
        checks++; if (fill !== 4'd8 || overflow !== 1'b1) begin
            errors++; $display("FAIL bp_full got fill=%0d ov=%0d want 8,1", fill, overflow); end
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (out_valid !== 1'b1 || int'($signed(out_data)) !== i) begin
                errors++; $display("FAIL bp_drain got v=%0d d=%0d want 1,%0d", out_valid, $signed(out_data), i); end
            step();
        end
        checks++; if (out_valid !== 1'b0 || fill !== 4'd0) begin
            errors++; $display("FAIL bp_empty got v=%0d fill=%0d want 0,0", out_valid, fill); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        shift = 5'd0; decim = 8'd1; out_ready = 1'b0;
        for (int j = 1; j <= 9; j++) begin data_in = j; in_valid = 1'b1; step(); end
        in_valid = 1'b0; out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (fill !== 4'd8 || overflow !== 1'b0 || int'($signed(out_data)) !== 2) begin
            errors++; $display("FAIL fpp_state got fill=%0d ov=%0d d=%0d want 8,0,2", fill, overflow, $signed(out_data)); end
        out_ready = 1'b1;
        for (int j = 2; j <= 9; j++) begin
            checks++; if (int'($signed(out_data)) !== j) begin
                errors++; $display("FAIL fpp_drain got %0d want %0d", $signed(out_data), j); end
            step();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        shift = 5'd0; decim = 8'd1; out_ready = 1'b0; in_valid = 1'b1;
        data_in = 32'h0001_0000;
        for (int i = 0; i < 4; i++) step();
        decim = 8'd4; data_in = 32'd5;
        step(); step();
        in_valid = 1'b0; step();
        checks++; if (fill !== 4'd5 || sat_flag !== 1'b1 || m_cnt !== 2) begin
            errors++; $display("FAIL mid_setup got fill=%0d sat=%0d want 5,1", fill, sat_flag); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || fill !== 4'd0 || sat_flag !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL mid_async got v=%0d fill=%0d sat=%0d ov=%0d want 0", out_valid, fill, sat_flag, overflow); end
        m_reset();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b1; data_in = 32'd7;
        step(); in_valid = 1'b0; step();
        checks++; if (out_valid !== 1'b1 || int'($signed(out_data)) !== 7) begin
            errors++; $display("FAIL mid_first_kept got v=%0d d=%0d want 1,7", out_valid, $signed(out_data)); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (c % 60 == 0) shift = 5'($urandom_range(0, 31));
            if (c % 45 == 0) decim = 8'($urandom_range(0, 5));
            in_valid    = ($urandom_range(0, 9) < 8);
            out_ready   = ($urandom_range(0, 9) < 5);
            clear_flags = ($urandom_range(0, 99) < 3);
            case ($urandom_range(0, 2))
                0: data_in = $urandom();
                1: data_in = 32'($signed(16'($urandom())));
                default: data_in = 32'($signed(20'($urandom())));
            endcase
            step();
            checks++; if (out_valid !== (m_q.size() > 0) || int'($signed(out_data)) !== m_head() ||
                          int'(fill) !== m_q.size() || sat_flag !== m_sat || overflow !== m_ov) begin
                errors++;
                $display("FAIL random c=%0d got v=%0d d=%0d fill=%0d sat=%0d ov=%0d want v=%0d d=%0d fill=%0d sat=%0d ov=%0d",
                         c, out_valid, $signed(out_data), fill, sat_flag, overflow,
                         m_q.size() > 0, m_head(), m_q.size(), m_sat, m_ov);
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; clear_flags = 1'b0; out_ready = 1'b0;
        data_in = '0; shift = '0; decim = 8'd1;
        m_reset();
        test_reset();
        test_basic();
        test_saturation();
        test_decimation();
        test_backpressure();
        test_full_push_pop();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
